sha_block_feeder: RTL and testbench
===================================

// Module: sha_block_feeder
// PURPOSE
//  Upstream feeder for the SHA-256 hashing stage. Holds the 3 header-tail words and a nonce range, then streams one
//  16-word second-block message per nonce: tail0..2, nonce, 0x80000000, 10x zero, 0x00000280 (640-bit length).
//  One 32-bit word per accepted handshake; the nonce carried with each block becomes the downstream index.
// PARAMETERS
//  WORD_W        32             message word width (fixed by SHA-256; not for override)
//  BLK_WORDS     16             words per emitted block
//  LEN_WORD      32'h00000280   final length word (80-byte header)
// PORTS
//  clk         in   1        system clock
//  rst         in   1        asynchronous, active-low reset (rst==0 resets)
//  cfg_valid   in   1        config write strobe
//  cfg_addr    in   3        0..2 tail word, 3 nonce_start, 4 nonce_end; 5..7 ignored
//  cfg_data    in   [0:31]   config write data
//  start       in   1        pulse: begin streaming from nonce_start
//  stop        in   1        pulse: abort streaming
//  block       out  [0:31]   current message word
//  block_valid out  1        block word valid
//  block_first out  1        word 0 of a block (qualifies block_valid)
//  block_ready in   1        downstream accepts word when block_valid && block_ready
//  index       out  [0:31]   nonce of the block currently on block
//  busy        out  1        state == STREAM
//  done        out  1        level: range exhausted, held until next start
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0 (block, index, valid, first, busy, done); tail/nonce regs 0.
//  - FSM: IDLE --start--> STREAM; STREAM --last word of nonce_end accepted--> DONE; STREAM --stop--> IDLE;
//    DONE --start--> STREAM (done clears same edge); DONE --stop--> IDLE (done clears).
//  - Config writes accepted only in IDLE/DONE; ignored in STREAM. Write and start same cycle: write lands, start
//    uses the new value (start is sampled after cfg update).
//  - Start: word_cnt<=0, nonce<=nonce_start; block_valid rises the cycle after start (latency 1), block_first=1.
//  - All outputs registered. Word held stable while block_valid && !block_ready (no change of block/index/first).
//  - word_cnt increments on each accepted word; on accept of word 15: word_cnt<=0, and if nonce==nonce_end ->
//    DONE (block_valid drops next cycle), else nonce<=nonce+1 mod 2^32, next word is word 0 of the new block.
//  - Wrap: nonce_start > nonce_end legal; sequence runs through 0xFFFFFFFF -> 0 until nonce_end.
//    nonce_start==nonce_end emits exactly one block. Full range 0..FFFFFFFF terminates on FFFFFFFF.
//  - Stop mid-block: block_valid deasserts next cycle; partial block is abandoned; downstream must discard it
//    (first word of any later block is flagged by block_first). stop and start same cycle: stop wins.
//  - start while STREAM ignored. Word content is a pure function of (word_cnt, tail regs, nonce).
//  - Async reset mid-stream: immediate return to reset values; no block completes.
// STRUCTURE
//  - bcx_pkg: feeder_state_e {IDLE, STREAM, DONE}; PAD_WORD=32'h80000000; LEN_WORD; BLK_WORDS; cfg addr localparams.
//  - Sub-module sha_pad_word: combinational word mux (word_cnt, tail[3], nonce) -> [0:31] word; rest is FSM,
//    4-bit word counter, nonce register and output register stage.
// TESTING
//  - Reset: rst=0 mid-stream -> all outputs 0 same cycle; after release, no block_valid until start.
//  - Single block: tail={11111111,22222222,33333333}, start=end=00000005, ready=1 -> 16 words
//    11111111,22222222,33333333,00000005,80000000,0x10,00000280; index=5; done=1 after word 15.
//  - Backpressure: toggle block_ready 0/1 randomly over nonce 0..3 -> 64 words, none dropped/duplicated, held stable while stalled.
//  - Wrap: start=FFFFFFFE, end=00000001 -> indices FFFFFFFE,FFFFFFFF,0,1 then done.
//  - Abort: stop at word 7 of nonce 9 -> valid low next cycle; new start -> word 0, index=nonce_start.
//  - Config during STREAM: write tail0=DEADBEEF while busy -> ignored; emitted word 0 unchanged.

Source files
------------

// File: rtl/bcx_pkg.sv
// Shared types and constants for the SHA-256 second-block feeder.
package bcx_pkg;

    localparam int WORD_W    = 32;
    localparam int BLK_WORDS = 16;

    typedef logic [0:WORD_W-1] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } feeder_state_e;

    localparam word_t PAD_WORD = 32'h8000_0000;
    localparam word_t LEN_WORD = 32'h0000_0280;

    localparam logic [3:0] LAST_WORD = 4'd15;

    localparam logic [2:0] CFG_TAIL0  = 3'd0;
    localparam logic [2:0] CFG_TAIL1  = 3'd1;
    localparam logic [2:0] CFG_TAIL2  = 3'd2;
    localparam logic [2:0] CFG_NSTART = 3'd3;
    localparam logic [2:0] CFG_NEND   = 3'd4;

endpackage

// File: rtl/sha_block_feeder_pad_word.sv
// Combinational word select for the padded 16-word second block of an 80-byte header.
module sha_pad_word
    import bcx_pkg::*;
(
    input  logic [3:0]     word_cnt_i,
    input  word_t [0:2]    tail_i,
    input  word_t          nonce_i,
    output word_t          word_o
);

    // Message layout: tail0..2, nonce, pad bit, zeros, bit length
    always_comb begin
        word_o = 32'h0000_0000;
        case (word_cnt_i)
            4'd0:    word_o = tail_i[0];
            4'd1:    word_o = tail_i[1];
            4'd2:    word_o = tail_i[2];
            4'd3:    word_o = nonce_i;
            4'd4:    word_o = PAD_WORD;
            4'd15:   word_o = LEN_WORD;
            default: word_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/sha_block_feeder.sv
// Streams one padded SHA-256 second block per nonce over a valid/ready word interface.
module sha_block_feeder
    import bcx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    input  logic [2:0]  cfg_addr,
    input  logic [0:31] cfg_data,
    input  logic        start,
    input  logic        stop,
    output logic [0:31] block,
    output logic        block_valid,
    output logic        block_first,
    input  logic        block_ready,
    output logic [0:31] index,
    output logic        busy,
    output logic        done
);

    feeder_state_e state_q, state_d;
    logic [3:0]    word_cnt_q, word_cnt_d;
    word_t         nonce_q, nonce_d;
    word_t [0:2]   tail_q, tail_d;
    word_t         nstart_q, nstart_d;
    word_t         nend_q, nend_d;
    word_t         block_q, block_d;
    word_t         index_q, index_d;
    logic          valid_q, valid_d;
    logic          first_q, first_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [3:0]    sel_cnt_s;
    word_t         sel_nonce_s;
    word_t         word_s;
    logic          accept_s;

    assign accept_s = valid_q && block_ready;

    // Config register update; frozen while streaming so a block never mixes old and new tails
    always_comb begin
        tail_d   = tail_q;
        nstart_d = nstart_q;
        nend_d   = nend_q;
        if (cfg_valid && (state_q != STREAM)) begin
            case (cfg_addr)
                CFG_TAIL0:  tail_d[0] = cfg_data;
                CFG_TAIL1:  tail_d[1] = cfg_data;
                CFG_TAIL2:  tail_d[2] = cfg_data;
                CFG_NSTART: nstart_d  = cfg_data;
                CFG_NEND:   nend_d    = cfg_data;
                default:    nstart_d  = nstart_q;
            endcase
        end else begin
            nend_d = nend_q;
        end
    end

    // Select which word will be loaded into the output register next
    always_comb begin
        sel_cnt_s   = 4'd0;
        sel_nonce_s = nstart_d;
        if (state_q != STREAM) begin
            sel_cnt_s   = 4'd0;
            sel_nonce_s = nstart_d;
        end else if (word_cnt_q == LAST_WORD) begin
            sel_cnt_s   = 4'd0;
            sel_nonce_s = nonce_q + 32'd1;
        end else begin
            sel_cnt_s   = word_cnt_q + 4'd1;
            sel_nonce_s = nonce_q;
        end
    end

    sha_pad_word u_pad_word (
        .word_cnt_i (sel_cnt_s),
        .tail_i     (tail_d),
        .nonce_i    (sel_nonce_s),
        .word_o     (word_s)
    );

    // Feeder FSM and output register next-state
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        nonce_d    = nonce_q;
        block_d    = block_q;
        index_d    = index_q;
        valid_d    = valid_q;
        first_d    = first_q;
        busy_d     = busy_q;
        done_d     = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (stop) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end else if (start) begin
                    state_d    = STREAM;
                    word_cnt_d = 4'd0;
                    nonce_d    = sel_nonce_s;
                    block_d    = word_s;
                    index_d    = sel_nonce_s;
                    valid_d    = 1'b1;
                    first_d    = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            STREAM: begin
                if (stop) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    first_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (accept_s) begin
                    word_cnt_d = sel_cnt_s;
                    // Last word of the final nonce ends the run instead of starting a new block
                    if ((word_cnt_q == LAST_WORD) && (nonce_q == nend_q)) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        first_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        nonce_d = sel_nonce_s;
                        block_d = word_s;
                        index_d = sel_nonce_s;
                        first_d = (sel_cnt_s == 4'd0);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                first_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State, counters, config and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            word_cnt_q <= 4'd0;
            nonce_q    <= 32'h0000_0000;
            tail_q     <= '{default: 32'h0000_0000};
            nstart_q   <= 32'h0000_0000;
            nend_q     <= 32'h0000_0000;
            block_q    <= 32'h0000_0000;
            index_q    <= 32'h0000_0000;
            valid_q    <= 1'b0;
            first_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            nonce_q    <= nonce_d;
            tail_q     <= tail_d;
            nstart_q   <= nstart_d;
            nend_q     <= nend_d;
            block_q    <= block_d;
            index_q    <= index_d;
            valid_q    <= valid_d;
            first_q    <= first_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign block       = block_q;
    assign index       = index_q;
    assign block_valid = valid_q;
    assign block_first = first_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_sha_block_feeder.sv
// Scoreboard bench: stimulus pushes expected words, a negedge monitor pops on each handshake.
module tb_sha_block_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic [2:0]  cfg_addr;
    logic [0:31] cfg_data;
    logic        start;
    logic        stop;
    logic [0:31] block;
    logic        block_valid;
    logic        block_first;
    logic        block_ready;
    logic [0:31] index;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] idx;
        logic        first;
    } exp_t;

    exp_t sb[$];
    logic [31:0] tl [3];

    logic        stalled;
    logic [31:0] held_w;
    logic [31:0] held_i;
    logic        held_f;

    sha_block_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .start       (start),
        .stop        (stop),
        .block       (block),
        .block_valid (block_valid),
        .block_first (block_first),
        .block_ready (block_ready),
        .index       (index),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_block(input logic [31:0] n, input int nwords);
        exp_t e;
        for (int i = 0; i < nwords; i++) begin
            if (i < 3)        e.w = tl[i];
            else if (i == 3)  e.w = n;
            else if (i == 4)  e.w = 32'h8000_0000;
            else if (i == 15) e.w = 32'h0000_0280;
            else              e.w = 32'h0000_0000;
            e.idx   = n;
            e.first = (i == 0);
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && !done; k++) tick();
        check("done_reached", {31'd0, done}, 32'd1);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("valid_after_done", {31'd0, block_valid}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);
    endtask

    // Monitor: compare each accepted word with the scoreboard head, and check stall stability
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled && block_valid) begin
                check("stall_word", block, held_w);
                check("stall_index", index, held_i);
                check("stall_first", {31'd0, block_first}, {31'd0, held_f});
            end
            if (block_valid && block_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", block, 32'hxxxx_xxxx);
                end else begin
                    e = sb.pop_front();
                    check("word", block, e.w);
                    check("index", index, e.idx);
                    check("first", {31'd0, block_first}, {31'd0, e.first});
                end
            end
            stalled = block_valid && !block_ready;
            held_w  = block;
            held_i  = index;
            held_f  = block_first;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b0;
        cfg_valid   = 1'b0;
        cfg_addr    = 3'd0;
        cfg_data    = 32'h0;
        start       = 1'b0;
        stop        = 1'b0;
        block_ready = 1'b1;
        stalled     = 1'b0;
        tl[0] = 32'h0; tl[1] = 32'h0; tl[2] = 32'h0;
        repeat (3) tick();
        check("rst_valid", {31'd0, block_valid}, 32'd0);
        check("rst_block", block, 32'd0);
        check("rst_index", index, 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        rst = 1'b1;
        tick();

        // Reset-default config: zero tails, single block at nonce 0
        push_block(32'h0, 16);
        pulse_start();
        wait_done(100);

        // Single block, start == end == 5
        tl[0] = 32'h1111_1111; tl[1] = 32'h2222_2222; tl[2] = 32'h3333_3333;
        cfg_write(3'd0, tl[0]);
        cfg_write(3'd1, tl[1]);
        cfg_write(3'd2, tl[2]);
        cfg_write(3'd3, 32'h5);
        cfg_write(3'd4, 32'h5);
        cfg_write(3'd7, 32'hFFFF_FFFF);
        push_block(32'h5, 16);
        pulse_start();
        check("start_latency_valid", {31'd0, block_valid}, 32'd1);
        check("start_first", {31'd0, block_first}, 32'd1);
        check("start_busy", {31'd0, busy}, 32'd1);
        wait_done(100);

        // Backpressure over nonces 0..3
        cfg_write(3'd3, 32'h0);
        cfg_write(3'd4, 32'h3);
        for (int n = 0; n < 4; n++) push_block(n, 16);
        pulse_start();
        for (int k = 0; k < 1000 && !done; k++) begin
            block_ready = 1'($urandom_range(0, 1));
            tick();
        end
        block_ready = 1'b1;
        wait_done(10);

        // Nonce wrap through 0xFFFFFFFF
        cfg_write(3'd3, 32'hFFFF_FFFE);
        cfg_write(3'd4, 32'h1);
        push_block(32'hFFFF_FFFE, 16);
        push_block(32'hFFFF_FFFF, 16);
        push_block(32'h0, 16);
        push_block(32'h1, 16);
        pulse_start();
        wait_done(200);

        // Abort at word 7 of nonce 9, then restart
        cfg_write(3'd3, 32'h9);
        cfg_write(3'd4, 32'hA);
        push_block(32'h9, 7);
        pulse_start();
        repeat (7) tick();
        check("abort_index", index, 32'h9);
        check("abort_first", {31'd0, block_first}, 32'd0);
        block_ready = 1'b0;
        stop        = 1'b1;
        tick();
        stop = 1'b0;
        check("abort_valid", {31'd0, block_valid}, 32'd0);
        check("abort_busy_done", {30'd0, busy, done}, 32'd0);
        block_ready = 1'b1;
        cfg_write(3'd4, 32'h9);
        push_block(32'h9, 16);
        pulse_start();
        check("restart_first", {31'd0, block_first}, 32'd1);
        check("restart_index", index, 32'h9);
        wait_done(100);

        // Config write and start in STREAM are ignored
        cfg_write(3'd3, 32'h20);
        cfg_write(3'd4, 32'h21);
        push_block(32'h20, 16);
        push_block(32'h21, 16);
        block_ready = 1'b0;
        pulse_start();
        cfg_write(3'd0, 32'hDEAD_BEEF);
        cfg_write(3'd4, 32'h20);
        pulse_start();
        block_ready = 1'b1;
        wait_done(100);

        // Write and start in the same cycle: start uses the new nonce_start
        cfg_write(3'd4, 32'h30);
        push_block(32'h30, 16);
        cfg_valid = 1'b1;
        cfg_addr  = 3'd3;
        cfg_data  = 32'h30;
        start     = 1'b1;
        tick();
        cfg_valid = 1'b0;
        start     = 1'b0;
        wait_done(100);

        // Stop and start together while DONE: stop wins
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("stop_wins_valid", {31'd0, block_valid}, 32'd0);
        check("stop_clears_done", {31'd0, done}, 32'd0);

        // Asynchronous reset mid-stream
        block_ready = 1'b0;
        pulse_start();
        check("pre_reset_valid", {31'd0, block_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, block_valid}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_block", block, 32'd0);
        check("async_rst_index", index, 32'd0);
        tick();
        rst = 1'b1;
        block_ready = 1'b1;
        sb.delete();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("post_reset_idle", {31'd0, block_valid}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
